// File: rtl/temp_loop_sequencer_pkg.sv
// Shared definitions for the temperature loop sequencer: state encodings, fault codes,
// temperature limits in 1/16 degC and a signed range helper.
package temp_loop_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_WAIT    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  localparam logic [1:0] FC_NONE         = 2'b00;
  localparam logic [1:0] FC_CONV_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_RANGE        = 2'b10;
  localparam logic [1:0] FC_PID_TIMEOUT  = 2'b11;

  localparam logic [11:0] TEMP_MIN_DEF = 12'hE70;  // -25.0 degC
  localparam logic [11:0] TEMP_MAX_DEF = 12'h640;  // 100.0 degC

  function automatic logic temp_in_range(input logic [11:0] t,
                                         input logic [11:0] lo,
                                         input logic [11:0] hi);
    return ($signed(t) >= $signed(lo)) && ($signed(t) <= $signed(hi));
  endfunction

endpackage

// File: rtl/temp_loop_sequencer_tick_timer.sv
// Saturating counter of tick strobes with synchronous clear; at_limit is high once
// the count has reached LIMIT and stays high until cleared.
module tick_timer #(
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count_reg;

  // clear beats a coincident tick so a restart always begins from zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en && tick && (count_reg != LIM)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_limit = (count_reg == LIM);

endmodule

// File: rtl/temp_loop_sequencer.sv
// Closed-loop temperature cycle sequencer: conversion with retries, range check,
// PID launch and duty commit at a PWM boundary, with a heater-off fault state.
module temp_loop_sequencer
  import temp_loop_sequencer_pkg::*;
#(
  parameter int          SAMPLE_TICKS  = 800,
  parameter int          TIMEOUT_TICKS = 1000,
  parameter int          MAX_RETRY     = 2,
  parameter logic [11:0] TEMP_MIN      = TEMP_MIN_DEF,
  parameter logic [11:0] TEMP_MAX      = TEMP_MAX_DEF,
  parameter int          DUTY_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1ms,
  input  logic              enable,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [11:0]       conv_data,
  output logic              pid_start,
  input  logic              pid_done,
  input  logic [DUTY_W-1:0] pid_duty,
  input  logic              pwm_period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic [11:0]       sample_out,
  output logic              sample_valid,
  output logic              fault,
  output logic [1:0]        fault_code,
  input  logic              fault_clr,
  output logic [2:0]        state_dbg
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t              state_reg;
  logic                conv_start_reg;
  logic                pid_start_reg;
  logic                sample_valid_reg;
  logic [11:0]         sample_reg;
  logic [11:0]         data_reg;
  logic [DUTY_W-1:0]   pending_reg;
  logic [DUTY_W-1:0]   duty_reg;
  logic                fault_reg;
  logic [1:0]          fault_code_reg;
  logic [RETRY_W-1:0]  retry_reg;

  logic sample_expired;
  logic timeout_expired;
  logic first_start;
  logic retry_now;
  logic timeout_en;
  logic timeout_clr;

  // A "first" conv_start restarts the sample period; retries do not.
  assign first_start = enable && ((state_reg == ST_IDLE) ||
                                  ((state_reg == ST_WAIT) && sample_expired));
  assign retry_now   = enable && (state_reg == ST_CONVERT) && !conv_done &&
                       timeout_expired && (retry_reg < RETRY_MAX);
  assign timeout_en  = (state_reg == ST_CONVERT) || (state_reg == ST_COMPUTE);
  assign timeout_clr = !timeout_en || retry_now;

  tick_timer #(.LIMIT(SAMPLE_TICKS - 1)) u_sample_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (first_start),
    .en       (1'b1),
    .tick     (tick_1ms),
    .at_limit (sample_expired)
  );

  tick_timer #(.LIMIT(TIMEOUT_TICKS)) u_timeout_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timeout_clr),
    .en       (timeout_en),
    .tick     (tick_1ms),
    .at_limit (timeout_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      conv_start_reg   <= 1'b0;
      pid_start_reg    <= 1'b0;
      sample_valid_reg <= 1'b0;
      sample_reg       <= '0;
      data_reg         <= '0;
      pending_reg      <= '0;
      duty_reg         <= '0;
      fault_reg        <= 1'b0;
      fault_code_reg   <= FC_NONE;
      retry_reg        <= '0;
    end else begin
      conv_start_reg   <= 1'b0;
      pid_start_reg    <= 1'b0;
      sample_valid_reg <= 1'b0;
      if ((state_reg != ST_FAULT) && !enable) begin
        state_reg <= ST_IDLE;
        duty_reg  <= '0;
        retry_reg <= '0;
      end else begin
        unique case (state_reg)
          ST_IDLE: begin
            state_reg      <= ST_CONVERT;
            conv_start_reg <= 1'b1;
            retry_reg      <= '0;
          end
          ST_CONVERT: begin
            if (conv_done) begin
              data_reg  <= conv_data;
              state_reg <= ST_CHECK;
            end else if (timeout_expired) begin
              if (retry_reg < RETRY_MAX) begin
                retry_reg      <= retry_reg + 1'b1;
                conv_start_reg <= 1'b1;
              end else begin
                state_reg      <= ST_FAULT;
                fault_reg      <= 1'b1;
                fault_code_reg <= FC_CONV_TIMEOUT;
                duty_reg       <= '0;
              end
            end
          end
          ST_CHECK: begin
            if (temp_in_range(data_reg, TEMP_MIN, TEMP_MAX)) begin
              sample_reg       <= data_reg;
              sample_valid_reg <= 1'b1;
              pid_start_reg    <= 1'b1;
              retry_reg        <= '0;
              state_reg        <= ST_COMPUTE;
            end else begin
              state_reg      <= ST_FAULT;
              fault_reg      <= 1'b1;
              fault_code_reg <= FC_RANGE;
              duty_reg       <= '0;
            end
          end
          ST_COMPUTE: begin
            if (pid_done) begin
              pending_reg <= pid_duty;
              state_reg   <= ST_COMMIT;
            end else if (timeout_expired) begin
              state_reg      <= ST_FAULT;
              fault_reg      <= 1'b1;
              fault_code_reg <= FC_PID_TIMEOUT;
              duty_reg       <= '0;
            end
          end
          ST_COMMIT: begin
            // a boundary in the pid_done cycle was sampled before COMMIT, so it is never used
            if (pwm_period_end) begin
              duty_reg  <= pending_reg;
              state_reg <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (sample_expired) begin
              state_reg      <= ST_CONVERT;
              conv_start_reg <= 1'b1;
            end
          end
          ST_FAULT: begin
            duty_reg <= '0;
            if (fault_clr) begin
              state_reg      <= ST_IDLE;
              fault_reg      <= 1'b0;
              fault_code_reg <= FC_NONE;
              retry_reg      <= '0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign conv_start   = conv_start_reg;
  assign pid_start    = pid_start_reg;
  assign sample_valid = sample_valid_reg;
  assign sample_out   = sample_reg;
  assign duty_out     = duty_reg;
  assign fault        = fault_reg;
  assign fault_code   = fault_code_reg;
  assign state_dbg    = state_reg;

endmodule

// File: tb/tb_temp_loop_sequencer.sv
// Directed bench for temp_loop_sequencer with SAMPLE_TICKS=20, TIMEOUT_TICKS=5, MAX_RETRY=2.
module tb_temp_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1ms = 1'b0;
  logic        enable = 1'b0;
  logic        conv_start;
  logic        conv_done = 1'b0;
  logic [11:0] conv_data = '0;
  logic        pid_start;
  logic        pid_done = 1'b0;
  logic [15:0] pid_duty = '0;
  logic        pwm_period_end = 1'b0;
  logic [15:0] duty_out;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        fault;
  logic [1:0]  fault_code;
  logic        fault_clr = 1'b0;
  logic [2:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  // tick index (ticks seen before that edge) of every conv_start pulse
  int tick_seen = 0;
  int starts_seen = 0;
  int start_tick[$];

  temp_loop_sequencer #(
    .SAMPLE_TICKS  (20),
    .TIMEOUT_TICKS (5),
    .MAX_RETRY     (2),
    .DUTY_W        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tick_1ms       (tick_1ms),
    .enable         (enable),
    .conv_start     (conv_start),
    .conv_done      (conv_done),
    .conv_data      (conv_data),
    .pid_start      (pid_start),
    .pid_done       (pid_done),
    .pid_duty       (pid_duty),
    .pwm_period_end (pwm_period_end),
    .duty_out       (duty_out),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .fault          (fault),
    .fault_code     (fault_code),
    .fault_clr      (fault_clr),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (conv_start) begin
      start_tick.push_back(tick_seen);
      starts_seen++;
    end
    if (tick_1ms) tick_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; tick_1ms = 1'b0; conv_done = 1'b0; pid_done = 1'b0;
    pwm_period_end = 1'b0; fault_clr = 1'b0; conv_data = '0; pid_duty = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // one tick strobe followed by three quiet cycles
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1'b1;
      step();
      tick_1ms = 1'b0;
      step();
      step();
      step();
    end
  endtask

  task automatic wait_conv_start(input string tag, input int limit);
    int n = 0;
    while (conv_start !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    check(tag, conv_start, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int t0;

    // ---- reset values and nominal cycle (tick every cycle) ----
    do_reset();
    check("rst_state", state_dbg, 0);
    check("rst_duty", duty_out, 0);
    check("rst_sample", sample_out, 0);
    check("rst_fault", {fault, fault_code}, 0);
    check("rst_pulses", {conv_start, pid_start, sample_valid}, 0);
    enable = 1'b1; tick_1ms = 1'b1;
    step();
    check("t1_conv_start", conv_start, 1);
    check("t1_convert", state_dbg, 1);
    step();
    step();
    conv_done = 1'b1; conv_data = 12'h190;
    step();
    conv_done = 1'b0;
    check("t1_check", state_dbg, 2);
    step();
    check("t1_sample", sample_out, 12'h190);
    check("t1_sample_valid", sample_valid, 1);
    check("t1_pid_start", pid_start, 1);
    check("t1_compute", state_dbg, 3);
    pid_done = 1'b1; pid_duty = 16'h4000;
    step();
    pid_done = 1'b0;
    check("t1_single_pulse", {pid_start, sample_valid}, 0);
    check("t1_commit", state_dbg, 4);
    check("t1_duty_before", duty_out, 0);
    pwm_period_end = 1'b1;
    step();
    pwm_period_end = 1'b0;
    check("t1_duty", duty_out, 16'h4000);
    check("t1_wait", state_dbg, 5);
    for (int c = 7; c < 20; c++) begin
      step();
      check("t1_no_early_start", conv_start, 0);
    end
    step();
    check("t1_restart_20", conv_start, 1);

    // ---- conversion timeouts, retries and fault ----
    do_reset();
    s0 = starts_seen; t0 = tick_seen;
    enable = 1'b1;
    step();
    run_ticks(14);
    check("t2_no_fault_14", fault, 0);
    run_ticks(1);
    check("t2_fault", fault, 1);
    check("t2_code", fault_code, 2'b01);
    check("t2_state", state_dbg, 6);
    check("t2_duty", duty_out, 0);
    check("t2_nstarts", starts_seen - s0, 3);
    if (starts_seen - s0 == 3) begin
      check("t2_start0", start_tick[s0] - t0, 0);
      check("t2_start1", start_tick[s0 + 1] - t0, 5);
      check("t2_start2", start_tick[s0 + 2] - t0, 10);
    end
    enable = 1'b0;
    step();
    check("t2_enable_ignored", state_dbg, 6);
    enable = 1'b1;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("t2_clr_idle", state_dbg, 0);
    check("t2_clr_fault", {fault, fault_code}, 0);
    step();
    check("t2_new_start", conv_start, 1);

    // ---- lower bound accepted, out-of-range sample faults ----
    do_reset();
    enable = 1'b1;
    step();
    conv_done = 1'b1; conv_data = 12'hE70;
    step();
    conv_done = 1'b0;
    step();
    check("t3_min_ok", sample_out, 12'hE70);
    pid_done = 1'b1; pid_duty = 16'h1234;
    step();
    pid_done = 1'b0;
    pwm_period_end = 1'b1;
    step();
    pwm_period_end = 1'b0;
    check("t3_duty", duty_out, 16'h1234);
    tick_1ms = 1'b1;
    wait_conv_start("t3_restart", 40);
    tick_1ms = 1'b0;
    conv_done = 1'b1; conv_data = 12'h7D0;
    step();
    conv_done = 1'b0;
    step();
    check("t3_fault_state", state_dbg, 6);
    check("t3_code", fault_code, 2'b10);
    check("t3_no_pid", {pid_start, sample_valid}, 0);
    check("t3_sample_kept", sample_out, 12'hE70);
    check("t3_duty_off", duty_out, 0);

    // ---- boundary coinciding with pid_done is skipped; upper bound accepted ----
    do_reset();
    enable = 1'b1;
    step();
    conv_done = 1'b1; conv_data = 12'h640;
    step();
    conv_done = 1'b0;
    step();
    check("t4_max_ok", sample_out, 12'h640);
    pid_done = 1'b1; pid_duty = 16'hABCD; pwm_period_end = 1'b1;
    step();
    pid_done = 1'b0; pwm_period_end = 1'b0;
    check("t4_skip_duty", duty_out, 0);
    step();
    step();
    check("t4_still_commit", state_dbg, 4);
    pwm_period_end = 1'b1;
    step();
    pwm_period_end = 1'b0;
    check("t4_duty", duty_out, 16'hABCD);

    // ---- enable dropped in COMMIT ----
    tick_1ms = 1'b1;
    wait_conv_start("t5_restart", 40);
    tick_1ms = 1'b0;
    conv_done = 1'b1; conv_data = 12'h100;
    step();
    conv_done = 1'b0;
    step();
    pid_done = 1'b1; pid_duty = 16'h8000;
    step();
    pid_done = 1'b0;
    check("t5_commit", state_dbg, 4);
    check("t5_old_duty", duty_out, 16'hABCD);
    enable = 1'b0;
    step();
    check("t5_idle", state_dbg, 0);
    check("t5_duty_zero", duty_out, 0);
    pwm_period_end = 1'b1;
    step();
    pwm_period_end = 1'b0;
    check("t5_pwm_ignored", duty_out, 0);

    // ---- reset mid-COMPUTE, coincident conv_done/timeout, PID timeout ----
    do_reset();
    enable = 1'b1;
    step();
    conv_done = 1'b1; conv_data = 12'h190;
    step();
    conv_done = 1'b0;
    step();
    check("t6_in_compute", state_dbg, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_state", state_dbg, 0);
    check("t6_rst_sample", sample_out, 0);
    check("t6_rst_outs", {conv_start, pid_start, sample_valid, fault, fault_code}, 0);
    step();
    check("t6_start", conv_start, 1);
    run_ticks(4);
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
    conv_done = 1'b1; conv_data = 12'h0FF;
    step();
    conv_done = 1'b0;
    check("t6_done_wins", state_dbg, 2);
    check("t6_no_retry", conv_start, 0);
    step();
    check("t6_pid_start", pid_start, 1);
    check("t6_sample", sample_out, 12'h0FF);
    run_ticks(5);
    check("t6_pid_timeout", state_dbg, 6);
    check("t6_pid_code", fault_code, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
